// File: rtl/wb_pkg.sv
// Shared widths and grant encoding for the register-file write-port arbiter.
package wb_pkg;
   localparam int XLEN     = 32;
   localparam int REG_W    = 5;
   localparam int NUM_REGS = 32;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_FIFO = 2'd2
   } grant_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback, long-unit, scoreboard and register-file port signals of the write-port arbiter.
interface wb_port_arbiter_if
   import wb_pkg::*;
#(
   parameter int XLEN = wb_pkg::XLEN
);
   logic             wb_valid;
   logic [REG_W-1:0] wb_reg;
   logic [XLEN-1:0]  wb_data;
   logic             wb_stall;
   logic             lu_valid;
   logic [REG_W-1:0] lu_reg;
   logic [XLEN-1:0]  lu_data;
   logic             lu_ready;
   logic             sb_set;
   logic [REG_W-1:0] sb_reg;
   logic [REG_W-1:0] rs1;
   logic [REG_W-1:0] rs2;
   logic             rs1_busy;
   logic             rs2_busy;
   logic [REG_W-1:0] wreg;
   logic [XLEN-1:0]  wdata;
   logic             wen;

   modport master (
      output wb_valid, wb_reg, wb_data, lu_valid, lu_reg, lu_data,
             sb_set, sb_reg, rs1, rs2,
      input  wb_stall, lu_ready, rs1_busy, rs2_busy, wreg, wdata, wen
   );

   modport slave (
      input  wb_valid, wb_reg, wb_data, lu_valid, lu_reg, lu_data,
             sb_set, sb_reg, rs1, rs2,
      output wb_stall, lu_ready, rs1_busy, rs2_busy, wreg, wdata, wen
   );
endinterface

// File: rtl/wb_result_fifo.sv
// Small power-of-two FIFO holding long-unit results ({reg, data}) awaiting a write-port slot.
module wb_result_fifo #(
   parameter  int W     = 37,
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [W-1:0]     i_wdata,
   input  logic             i_pop,
   output logic [W-1:0]     o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);
   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is data only; validity is carried entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between writeback and buffered
// long-unit results, and tracks registers with outstanding long-unit writes.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int XLEN       = wb_pkg::XLEN,
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_WAIT   = 4
) (
   input  logic          clk,
   input  logic          reset,
   wb_port_arbiter_if.slave bus
);
   localparam int AGE_W = $clog2(MAX_WAIT + 1);
   localparam int ENT_W = REG_W + XLEN;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [AGE_W-1:0]    r_age;
   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic [ENT_W-1:0]    w_head;
   logic [REG_W-1:0]    w_head_reg;
   logic [XLEN-1:0]     w_head_data;
   logic                w_full;
   logic                w_empty;
   logic [CNT_W-1:0]    w_count;
   logic                w_force;
   logic                w_pop;
   grant_e              w_grant;

   function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
      return (a >= AGE_W'(MAX_WAIT)) ? a : a + 1'b1;
   endfunction

   wb_result_fifo #(
      .W     (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (bus.lu_valid),
      .i_wdata ({bus.lu_reg, bus.lu_data}),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign {w_head_reg, w_head_data} = w_head;
   assign w_force = ~w_empty & ((r_age >= AGE_W'(MAX_WAIT)) | w_full);

   always_comb begin
      w_grant = GNT_NONE;
      if (reset)              w_grant = GNT_NONE;
      else if (w_force)       w_grant = GNT_FIFO;
      else if (bus.wb_valid)  w_grant = GNT_PIPE;
      else if (~w_empty)      w_grant = GNT_FIFO;
   end

   assign w_pop        = (w_grant == GNT_FIFO);
   assign bus.wreg     = w_pop ? w_head_reg  : bus.wb_reg;
   assign bus.wdata    = w_pop ? w_head_data : bus.wb_data;
   assign bus.wen      = (w_grant != GNT_NONE) & (bus.wreg != '0);
   assign bus.wb_stall = w_pop & bus.wb_valid;
   assign bus.lu_ready = ~w_full & ~reset;
   assign bus.rs1_busy = r_busy[bus.rs1];
   assign bus.rs2_busy = r_busy[bus.rs2];

   // Age only advances while a buffered result is being passed over by the pipeline.
   always_ff @(posedge clk) begin
      if (reset)                      r_age <= '0;
      else if (w_pop | w_empty)       r_age <= '0;
      else if (w_grant == GNT_PIPE)   r_age <= age_inc(r_age);
   end

   always_comb begin
      w_busy_nxt = r_busy;
      if (w_pop) w_busy_nxt[w_head_reg] = 1'b0;
      if (bus.sb_set && (bus.sb_reg != '0)) w_busy_nxt[bus.sb_reg] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) r_busy <= '0;
      else       r_busy <= w_busy_nxt;
   end

   a_push_ready: assert property (@(posedge clk) disable iff (reset)
      !(bus.lu_valid && !bus.lu_ready));
   a_pipe_waw: assert property (@(posedge clk) disable iff (reset)
      !((w_grant == GNT_PIPE) && bus.wen && r_busy[bus.wb_reg]));
   a_count_range: assert property (@(posedge clk) disable iff (reset)
      w_count <= CNT_W'(FIFO_DEPTH));
endmodule
